// File: rtl/alu_issue_queue.sv
// ============================================================================
//  Module   : alu_issue_queue
//  Purpose  : FIFO of ALU commands issued one at a time to an external ALU;
//             results are held with a valid/ready handshake. Optional
//             statistics ports are enabled by the ALU_ISSUE_STATS_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_queue #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   in_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [OP_W-1:0]   out_op,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0]       issue_count,
    output logic              drop_flag,
`endif
    output logic              busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = 2 * DATA_W + OP_W;
    localparam int LAT_W = 3;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ALU_LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [LAT_W-1:0]  lat_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [OP_W-1:0]   alu_op_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_r_q;
    logic [OP_W-1:0]   out_op_q;

    logic              full;
    logic              push;
    logic              pop;
    logic              lat_done;
    logic [ENT_W-1:0]  head;

    assign full     = (count_q == FULL_CNT);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // Popping only on a count that was already non-zero before the edge
    // keeps a freshly pushed entry from being issued in the same cycle.
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign lat_done = (lat_q == LAT_LAST);
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_op, in_b, in_a};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop)       state_d = S_WAIT;
            S_WAIT:  if (lat_done)  state_d = S_HOLD;
            S_HOLD:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && pop) begin
                alu_a_q  <= head[DATA_W-1:0];
                alu_b_q  <= head[2*DATA_W-1:DATA_W];
                alu_op_q <= head[ENT_W-1:2*DATA_W];
                lat_q    <= '0;
            end
            if (state_q == S_WAIT) begin
                lat_q <= lat_q + LAT_W'(1);
                if (lat_done) begin
                    out_r_q     <= alu_r;
                    out_op_q    <= alu_op_q;
                    out_valid_q <= 1'b1;
                end
            end
            if (state_q == S_HOLD && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issue_count_q;
    logic        drop_flag_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_count_q <= '0;
            drop_flag_q   <= 1'b0;
        end else begin
            if (pop) begin
                issue_count_q <= issue_count_q + 16'd1;
            end
            if (in_valid && full) begin
                drop_flag_q <= 1'b1;
            end
        end
    end

    assign issue_count = issue_count_q;
    assign drop_flag   = drop_flag_q;
`endif

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_op    = out_op_q;
    assign busy      = (count_q != '0) || (state_q != S_IDLE);

endmodule

`default_nettype wire
